stl_uart_host: RTL and testbench

STL_UART_HOST -- requirements
Module: stl_uart_host

---
 rtl/stl_uart_pkg.sv | 25 ++
 rtl/stl_timeout_counter.sv | 44 ++++
 rtl/stl_uart_host.sv | 164 ++++++++++++++++
 tb/tb_stl_uart_host.sv | 318 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/stl_uart_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : stl_uart_pkg
//  Description : Shared packet geometry and FSM state encoding for the
//                STL UART host/client pair.
//  Revision    : 1.0 - initial release
// ============================================================================
package stl_uart_pkg;

  // Bytes carried by one request or one response packet.
  localparam int PACKET_SIZE = 16;

  // Byte counter carries one spare bit so it can never wrap inside a packet.
  localparam int BYTE_CNT_W = $clog2(PACKET_SIZE) + 1;

  // Transaction state encoding.
  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_SEND    = 2'd1,
    ST_COLLECT = 2'd2,
    ST_DELIVER = 2'd3
  } uart_state_e;

endpackage
`default_nettype wire

// File: rtl/stl_timeout_counter.sv
`default_nettype none
// ============================================================================
//  Module      : stl_timeout_counter
//  Description : Idle-cycle counter. Counts enabled cycles, restarts on
//                clear, and flags a single-cycle expiry when the count
//                reaches the limit. Clear always beats expiry.
//  Revision    : 1.0 - initial release
// ============================================================================
module stl_timeout_counter #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             enable,
  input  logic [WIDTH-1:0] limit,
  output logic             expired
);

  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] count_d;

  // Next count and expiry flag; the counter restarts after expiring so it never wraps.
  always_comb begin
    expired = enable && !clear && (count_q == limit);
    count_d = count_q;
    if (clear || expired) begin
      count_d = '0;
    end else if (enable) begin
      count_d = count_q + WIDTH'(1);
    end
  end

  // Count register.
  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule
`default_nettype wire

// File: rtl/stl_uart_host.sv
`default_nettype none
// ============================================================================
//  Module      : stl_uart_host
//  Description : Packet host for a byte-wide UART. Serialises a request
//                packet onto the transmitter, gathers a response packet of
//                the same size from the receiver and hands it over, abandoning
//                the response if the receiver goes quiet for too long.
//  Revision    : 1.0 - initial release
// ============================================================================
module stl_uart_host #(
  parameter int CLOCK_FREQ     = 100_000_000,
  parameter int PACKET_SIZE    = 16,
  parameter int TIMEOUT_CYCLES = CLOCK_FREQ / 100
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     req_valid,
  output logic                     req_ready,
  input  logic [PACKET_SIZE*8-1:0] req_data,
  output logic                     tx_valid,
  input  logic                     tx_ready,
  output logic [7:0]               tx_data,
  input  logic                     rx_valid,
  output logic                     rx_ready,
  input  logic [7:0]               rx_data,
  output logic                     resp_valid,
  input  logic                     resp_ready,
  output logic [PACKET_SIZE*8-1:0] resp_data,
  output logic                     timeout,
  output logic                     stray_byte,
  output logic                     busy
);

  import stl_uart_pkg::*;

  localparam int DATA_W = PACKET_SIZE * 8;
  localparam int CNT_W  = $clog2(PACKET_SIZE) + 1;
  localparam int TO_W   = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] C_LAST_BYTE = CNT_W'(PACKET_SIZE - 1);
  localparam logic [TO_W-1:0]  C_TO_LIMIT  = TO_W'(TIMEOUT_CYCLES - 1);

  uart_state_e       state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [DATA_W-1:0] tx_q, tx_d;
  logic [DATA_W-1:0] rx_q, rx_d;
  logic              timeout_q, timeout_d;
  logic              stray_q, stray_d;

  logic              last_byte;
  logic              tx_hs;
  logic              collect_hs;
  logic              to_clear;
  logic              to_enable;
  logic              to_expired;

  assign last_byte  = (cnt_q == C_LAST_BYTE);
  assign tx_hs      = (state_q == ST_SEND) && tx_ready;
  assign collect_hs = (state_q == ST_COLLECT) && rx_valid;
  // Idle counting only runs while collecting; any accepted byte restarts it.
  assign to_enable  = (state_q == ST_COLLECT);
  assign to_clear   = !to_enable || collect_hs;

  stl_timeout_counter #(
    .WIDTH (TO_W)
  ) u_timeout (
    .clk     (clk),
    .rst     (reset),
    .clear   (to_clear),
    .enable  (to_enable),
    .limit   (C_TO_LIMIT),
    .expired (to_expired)
  );

  // State and datapath registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      tx_q      <= '0;
      rx_q      <= '0;
      timeout_q <= 1'b0;
      stray_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      tx_q      <= tx_d;
      rx_q      <= rx_d;
      timeout_q <= timeout_d;
      stray_q   <= stray_d;
    end
  end

  // Next-state logic; a received byte takes priority over a coincident expiry.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:    if (req_valid) state_d = ST_SEND;
      ST_SEND:    if (tx_hs && last_byte) state_d = ST_COLLECT;
      ST_COLLECT: begin
        if (collect_hs) begin
          if (last_byte) state_d = ST_DELIVER;
        end else if (to_expired) begin
          state_d = ST_IDLE;
        end
      end
      ST_DELIVER: if (resp_ready) state_d = ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase
  end

  // Datapath updates: shift registers, byte counter and status pulses.
  always_comb begin
    cnt_d     = cnt_q;
    tx_d      = tx_q;
    rx_d      = rx_q;
    timeout_d = 1'b0;
    stray_d   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        stray_d = rx_valid;
        if (req_valid) begin
          tx_d  = req_data;
          cnt_d = '0;
        end
      end
      ST_SEND: begin
        stray_d = rx_valid;
        if (tx_hs) begin
          tx_d  = tx_q >> 8;
          cnt_d = last_byte ? '0 : cnt_q + CNT_W'(1);
        end
      end
      ST_COLLECT: begin
        if (collect_hs) begin
          rx_d  = {rx_data, rx_q[DATA_W-1:8]};
          cnt_d = last_byte ? '0 : cnt_q + CNT_W'(1);
        end else if (to_expired) begin
          // Abandon the partial response.
          rx_d      = '0;
          cnt_d     = '0;
          timeout_d = 1'b1;
        end
      end
      default: begin
        cnt_d = cnt_q;
      end
    endcase
  end

  // Port outputs decoded from the current state and registers.
  always_comb begin
    req_ready  = (state_q == ST_IDLE);
    tx_valid   = (state_q == ST_SEND);
    rx_ready   = (state_q != ST_DELIVER);
    resp_valid = (state_q == ST_DELIVER);
    busy       = (state_q != ST_IDLE);
    tx_data    = tx_q[7:0];
    resp_data  = rx_q;
    timeout    = timeout_q;
    stray_byte = stray_q;
  end

endmodule
`default_nettype wire

// File: tb/tb_stl_uart_host.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module      : tb_stl_uart_host
//  Description : Scoreboard bench for stl_uart_host with randomised packets.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_stl_uart_host;

  localparam int PS = 16;
  localparam int TO = 50;
  localparam int DW = PS * 8;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          req_valid = 1'b0;
  logic          req_ready;
  logic [DW-1:0] req_data = '0;
  logic          tx_valid;
  logic          tx_ready = 1'b0;
  logic [7:0]    tx_data;
  logic          rx_valid = 1'b0;
  logic          rx_ready;
  logic [7:0]    rx_data = '0;
  logic          resp_valid;
  logic          resp_ready = 1'b0;
  logic [DW-1:0] resp_data;
  logic          timeout;
  logic          stray_byte;
  logic          busy;

  always #5 clk = ~clk;

  stl_uart_host #(
    .CLOCK_FREQ     (100_000_000),
    .PACKET_SIZE    (PS),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_data   (req_data),
    .tx_valid   (tx_valid),
    .tx_ready   (tx_ready),
    .tx_data    (tx_data),
    .rx_valid   (rx_valid),
    .rx_ready   (rx_ready),
    .rx_data    (rx_data),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_data  (resp_data),
    .timeout    (timeout),
    .stray_byte (stray_byte),
    .busy       (busy)
  );

  int errors = 0;
  int checks = 0;
  int timeout_pulses = 0;
  int stray_pulses = 0;

  logic [7:0]    tx_exp[$];
  logic [DW-1:0] resp_exp[$];

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    checks++;
    errors++;
    $display("FAIL %s", name);
  endtask

  // Monitor: pops expectations on every output handshake and checks stall stability.
  logic          prev_tx_stall = 1'b0;
  logic          prev_resp_stall = 1'b0;
  logic [7:0]    prev_tx = '0;
  logic [DW-1:0] prev_resp = '0;

  always @(negedge clk) begin
    if (reset) begin
      prev_tx_stall   = 1'b0;
      prev_resp_stall = 1'b0;
    end else begin
      if (tx_valid && prev_tx_stall) check("tx_hold", tx_data, prev_tx);
      if (resp_valid && prev_resp_stall) check("resp_hold", resp_data, prev_resp);
      if (tx_valid && tx_ready) begin
        if (tx_exp.size() == 0) fail_now("tx_unexpected_byte");
        else check("tx_byte", tx_data, tx_exp.pop_front());
      end
      if (resp_valid && resp_ready) begin
        if (resp_exp.size() == 0) fail_now("resp_unexpected");
        else check("resp_data", resp_data, resp_exp.pop_front());
      end
      if (timeout) timeout_pulses++;
      if (stray_byte) stray_pulses++;
      prev_tx_stall   = tx_valid && !tx_ready;
      prev_tx         = tx_data;
      prev_resp_stall = resp_valid && !resp_ready;
      prev_resp       = resp_data;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // mode: 0 = tx_ready held high, 1 = toggling, 2 = random
  task automatic do_request(input logic [DW-1:0] d, input int mode);
    int n;
    n = 0;
    while (!req_ready && n < 200) begin tick(); n++; end
    if (!req_ready) fail_now("req_ready_wait");
    for (int i = 0; i < PS; i++) tx_exp.push_back(d[i*8 +: 8]);
    req_data  = d;
    req_valid = 1'b1;
    tx_ready  = 1'b0;
    tick();
    req_valid = 1'b0;
    n = 0;
    while (tx_exp.size() != 0 && n < 400) begin
      case (mode)
        0:       tx_ready = 1'b1;
        1:       tx_ready = ~tx_ready;
        default: tx_ready = 1'($urandom_range(0, 1));
      endcase
      tick();
      n++;
    end
    if (tx_exp.size() != 0) begin
      fail_now("tx_drain_timeout");
      tx_exp.delete();
    end
    tx_ready = 1'b0;
  endtask

  // Sends nb bytes with random gaps; a full packet queues its expected response.
  task automatic do_collect(input int nb, input int max_gap);
    logic [DW-1:0] exp;
    logic [7:0]    b;
    exp = '0;
    for (int i = 0; i < nb; i++) begin
      rx_valid = 1'b0;
      repeat ($urandom_range(0, max_gap)) tick();
      b = 8'($urandom);
      exp[i*8 +: 8] = b;
      rx_valid = 1'b1;
      rx_data  = b;
      check("rx_ready_collect", rx_ready, 1);
      if (i == PS - 1) resp_exp.push_back(exp);
      tick();
    end
    rx_valid = 1'b0;
  endtask

  task automatic do_deliver(input int stall);
    int n;
    resp_ready = 1'b0;
    n = 0;
    while (!resp_valid && n < 200) begin tick(); n++; end
    if (!resp_valid) fail_now("resp_valid_wait");
    check("rx_ready_deliver", rx_ready, 0);
    repeat (stall) tick();
    resp_ready = 1'b1;
    n = 0;
    while (resp_exp.size() != 0 && n < 50) begin tick(); n++; end
    if (resp_exp.size() != 0) begin
      fail_now("resp_drain_timeout");
      resp_exp.delete();
    end
    resp_ready = 1'b0;
    check("req_ready_after_resp", req_ready, 1);
  endtask

  function automatic logic [DW-1:0] rand_packet();
    logic [DW-1:0] p;
    for (int i = 0; i < DW / 32; i++) p[i*32 +: 32] = $urandom;
    return p;
  endfunction

  initial begin
    logic [DW-1:0] d;
    int t0;
    int s0;

    // Reset values
    reset = 1'b1;
    repeat (3) tick();
    check("rst_req_ready", req_ready, 1);
    check("rst_rx_ready", rx_ready, 1);
    check("rst_tx_valid", tx_valid, 0);
    check("rst_resp_valid", resp_valid, 0);
    check("rst_timeout", timeout, 0);
    check("rst_stray", stray_byte, 0);
    check("rst_busy", busy, 0);
    check("rst_tx_data", tx_data, 0);
    check("rst_resp_data", resp_data, 0);
    reset = 1'b0;
    tick();

    // Full-speed directed packet: counting bytes out, A0..AF back, minimum latency
    d = 128'h0F0E0D0C0B0A09080706050403020100;
    for (int i = 0; i < PS; i++) tx_exp.push_back(8'(i));
    req_data  = d;
    req_valid = 1'b1;
    tx_ready  = 1'b1;
    tick();
    req_valid = 1'b0;
    check("first_byte_presented", tx_data, 8'h00);
    repeat (PS) tick();
    check("tx_all_sent", tx_exp.size(), 0);
    check("collect_busy", busy, 1);
    check("collect_tx_valid", tx_valid, 0);
    check("collect_req_ready", req_ready, 0);
    check("collect_rx_ready", rx_ready, 1);
    tx_ready = 1'b0;
    resp_exp.push_back(128'hAFAEADACABAAA9A8A7A6A5A4A3A2A1A0);
    for (int i = 0; i < PS; i++) begin
      rx_valid = 1'b1;
      rx_data  = 8'hA0 + 8'(i);
      if (i == PS - 1) check("resp_latency_early", resp_valid, 0);
      tick();
    end
    rx_valid = 1'b0;
    check("resp_latency", resp_valid, 1);
    do_deliver(5);

    // tx_ready toggling every other cycle
    do_request(rand_packet(), 1);
    do_collect(PS, 0);
    do_deliver(0);

    // Timeout after 7 bytes
    t0 = timeout_pulses;
    do_request(rand_packet(), 0);
    resp_ready = 1'b1;
    do_collect(7, 0);
    repeat (TO - 1) tick();
    check("timeout_not_yet", timeout, 0);
    check("timeout_busy_before", busy, 1);
    tick();
    check("timeout_pulse", timeout, 1);
    check("timeout_idle", busy, 0);
    check("timeout_req_ready", req_ready, 1);
    tick();
    check("timeout_pulse_end", timeout, 0);
    check("timeout_pulse_count", timeout_pulses - t0, 1);
    resp_ready = 1'b0;

    // Stray byte in IDLE, then a clean transaction
    s0 = stray_pulses;
    rx_valid = 1'b1;
    rx_data  = 8'h55;
    tick();
    rx_valid = 1'b0;
    check("stray_pulse", stray_byte, 1);
    tick();
    check("stray_pulse_end", stray_byte, 0);
    do_request(rand_packet(), 0);
    do_collect(PS, 2);
    do_deliver(1);
    check("stray_count", stray_pulses - s0, 1);

    // Reset while byte 8 is on the transmitter
    t0 = timeout_pulses;
    d = rand_packet();
    for (int i = 0; i < PS; i++) tx_exp.push_back(d[i*8 +: 8]);
    req_data  = d;
    req_valid = 1'b1;
    tx_ready  = 1'b1;
    tick();
    req_valid = 1'b0;
    repeat (8) tick();
    check("abort_byte8", tx_data, d[64 +: 8]);
    reset = 1'b1;
    tick();
    tx_exp.delete();
    check("abort_tx_valid", tx_valid, 0);
    check("abort_req_ready", req_ready, 1);
    check("abort_timeout", timeout, 0);
    reset = 1'b0;
    tx_ready = 1'b0;
    tick();
    do_request(rand_packet(), 0);
    do_collect(PS, 1);
    do_deliver(0);
    check("abort_no_timeout", timeout_pulses - t0, 0);

    // Random transactions
    for (int k = 0; k < 6; k++) begin
      do_request(rand_packet(), int'($urandom_range(0, 2)));
      do_collect(PS, int'($urandom_range(0, 3)));
      do_deliver(int'($urandom_range(0, 4)));
    end

    tick();
    check("tx_queue_drained", tx_exp.size(), 0);
    check("resp_queue_drained", resp_exp.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

endmodule
`default_nettype wire
